rv_plic_claim_gateway: RTL and testbench
========================================

# rv_plic_claim_gateway

Per-target interrupt gateway and claim/complete controller for the custom RV PLIC. It converts raw level- or edge-triggered source lines into the pending vector `ip_o` that the per-target priority/threshold arbiter consumes. It closes the loop on the arbiter's registered `irq`/`irq_id` result by servicing hart claim reads and complete writes. It also tracks which sources are in service, so a source cannot re-pend until its completion arrives.

## Interface
- `N_SOURCE`, default 32: number of sources, including reserved ID 0.
- `SrcWidth`, default `$clog2(N_SOURCE)`: localparam, ID width; not overridable.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; one clock, reset is asynchronous and active-low.
- `src_i`  in  N_SOURCE  raw interrupt lines; bit 0 ignored.
- `le_i`  in  N_SOURCE  trigger mode per source: 1 = rising edge, 0 = level-high.
- `irq_i`  in  1  registered request from the priority/threshold arbiter.
- `irq_id_i`  in  SrcWidth  registered winning ID from the arbiter; 0 when none.
- `claim_re_i`  in  1  single-cycle claim read strobe.
- `claim_rvalid_o`  out  1  claim response valid.
- `claim_id_o`  out  SrcWidth  claimed ID; 0 means nothing claimable.
- `complete_we_i`  in  1  single-cycle complete write strobe.
- `complete_id_i`  in  SrcWidth  ID being completed.
- `ip_o`  out  N_SOURCE  pending vector to the arbiter; equals `ip_q`.
- `ia_o`  out  N_SOURCE  in-service vector, for debug/CSR readback; equals `ia_q`.

## Operation
State per source i:
- `ip_q[i]`: pending.
- `ia_q[i]`: active, meaning pending or claimed and not yet completed.
- `src_q[i]`: previous sample, used for edge detection.

Bit 0 of `ip_q`, `ia_q` and `src_q` is hardwired 0.

Trigger and set:
- `set[i] = le_i[i] ? (s[i] & ~src_q[i]) : s[i]`.
- `s` is `src_i`, or the synchronized `src_i` when the sync option is compiled in (see Configuration).
- When `set[i] & ~ia_q[i]`: `ip_q[i]` and `ia_q[i]` both go to 1 at the next edge.
- When `ia_q[i]` is already 1, the set is dropped. Edges arriving during service are lost; a level source re-pends after completion if still high.

Claim:
- On `claim_re_i`, compute `hit = irq_i & ip_q[irq_id_i] & (irq_id_i != 0)`.
- Next cycle: `claim_rvalid_o = 1` and `claim_id_o = hit ? irq_id_i : 0`.
- On a hit, `ip_q[irq_id_i]` clears at the same edge; `ia_q` is unchanged.
- The `ip_q` check guards against the arbiter's stale registered result, so back-to-back claims never return the same ID twice.

Complete:
- On `complete_we_i` with ID c: `ia_q[c]` clears at the next edge only if all of the following hold: `c != 0`, `c < N_SOURCE`, `ia_q[c] = 1`, `ip_q[c] = 0` (already claimed).
- Otherwise the write is silently ignored.

Simultaneous events:
- Claim of X and complete of X in the same cycle: the complete sees `ip_q[X] = 1` and is ignored. The claim proceeds.
- Complete of X and `set[X]` in the same cycle: the set is blocked, because `ia_q[X]` is still 1. A level source re-pends one cycle later.
- Claim and complete of different IDs in the same cycle: both take effect.

Reset:
- All flops clear: `ip_o = 0`, `ia_o = 0`, `claim_rvalid_o = 0`, `claim_id_o = 0`, `src_q = 0`.
- A source already high at reset release counts as a rising edge on the first sample.
- A claim or complete in flight at reset assertion is discarded; no response is produced.

## Timing
- `src_i` to `ip_o`: 1 cycle, or 3 cycles with the sync option.
- `ip_o` to arbiter `irq_i`: 1 cycle (arbiter register). Source to `irq_i` totals 2 cycles.
- Claim response: exactly 1 cycle after `claim_re_i`. `claim_rvalid_o` is a 1-cycle pulse per strobe. Strobes may be issued every cycle.
- Complete: takes effect at the edge ending the strobe cycle. No response.
- `claim_id_o` holds its last value between pulses and is 0 after reset.

## Configuration
- `RV_PLIC_GW_SYNC_EN` defined: a two-flop synchronizer, reset to 0, is inserted on every `src_i` bit before edge/level detection. Source-to-`ip_o` latency becomes 3 cycles.
- `RV_PLIC_GW_SYNC_EN` undefined: `src_i` is assumed synchronous to `clk_i` and sampled directly. Latency is 1 cycle.

## Test plan
- Level source 5 held high. Expected: `ip_o[5] = 1` at cycle 1. A claim at cycle 3 returns 5; `ip_o[5] = 0`, `ia_o[5] = 1`. Complete(5) clears `ia_o[5]`. `ip_o[5]` re-asserts 1 cycle later.
- Edge source 3: pulse, claim, then 2 more pulses before complete. Expected: claim returns 3 once. No re-pend after complete. A new pulse after complete re-pends.
- Sources 2 and 7 pending, arbiter picks 7. Issue claims on back-to-back cycles. Expected: the first returns 7. The second returns 0 while `irq_id_i` is stale at 7, never 7 twice.
- Claim with `irq_i = 0`. Expected: `claim_id_o = 0`; `ip_o` unchanged.
- Complete(4) while `ip_q[4] = 1`; also complete(0), and complete(9) with `ia_q[9] = 0`. Expected: all ignored, `ia_o` unchanged. Claim(6) and complete(6) in the same cycle: ID 6 is returned, and `ia_o[6]` stays 1.
- Assert `rst_ni` low mid-claim, with `claim_re_i` high. Expected: no `claim_rvalid_o`. All outputs read 0. With `RV_PLIC_GW_SYNC_EN` defined, source-to-`ip_o` latency measures 3 cycles.

Source files
------------

// File: rtl/rv_plic_claim_gateway.sv
// Per-target PLIC gateway: converts raw source lines into the pending vector and
// services claim reads / complete writes. Define RV_PLIC_GW_SYNC_EN to add a
// two-flop synchronizer on every source line.

// One source's gateway state: pending, in-service and previous-sample flops.
module rv_plic_gw_cell #(
  parameter bit EN = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic s,
  input  logic le,
  input  logic claim_clr,
  input  logic complete_clr,
  output logic ip,
  output logic ia
);
  logic src_q, ip_q, ia_q, set;

  // EN=0 pins the reserved ID's flops at their reset value of 0.
  assign set = EN & (le ? (s & ~src_q) : s);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q <= 1'b0;
      ip_q  <= 1'b0;
      ia_q  <= 1'b0;
    end else begin
      src_q <= s;
      if (set && !ia_q) begin
        ip_q <= 1'b1;
        ia_q <= 1'b1;
      end else begin
        // Claim needs ip=1 and complete needs ip=0, so they never collide.
        if (claim_clr)    ip_q <= 1'b0;
        if (complete_clr) ia_q <= 1'b0;
      end
    end
  end

  assign ip = ip_q;
  assign ia = ia_q;
endmodule

module rv_plic_claim_gateway #(
  parameter  int N_SOURCE = 32,
  localparam int SrcWidth = $clog2(N_SOURCE)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_SOURCE-1:0] src_i,
  input  logic [N_SOURCE-1:0] le_i,
  input  logic                irq_i,
  input  logic [SrcWidth-1:0] irq_id_i,
  input  logic                claim_re_i,
  output logic                claim_rvalid_o,
  output logic [SrcWidth-1:0] claim_id_o,
  input  logic                complete_we_i,
  input  logic [SrcWidth-1:0] complete_id_i,
  output logic [N_SOURCE-1:0] ip_o,
  output logic [N_SOURCE-1:0] ia_o
);
  logic [N_SOURCE-1:0] s, ip_q, ia_q, claim_clr, complete_clr;
  logic                hit, claim_rvalid_q;
  logic [SrcWidth-1:0] claim_id_q;

`ifdef RV_PLIC_GW_SYNC_EN
  logic [N_SOURCE-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = src_i;
`endif

  // Decoding against ip_q rejects a stale arbiter ID after a back-to-back claim.
  for (genvar i = 0; i < N_SOURCE; i++) begin : g_src
    assign claim_clr[i]    = claim_re_i & irq_i & (irq_id_i == SrcWidth'(i)) & ip_q[i];
    assign complete_clr[i] = complete_we_i & (complete_id_i == SrcWidth'(i))
                             & ia_q[i] & ~ip_q[i];

    rv_plic_gw_cell #(.EN(i != 0)) u_cell (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .s            (s[i]),
      .le           (le_i[i]),
      .claim_clr    (claim_clr[i]),
      .complete_clr (complete_clr[i]),
      .ip           (ip_q[i]),
      .ia           (ia_q[i])
    );
  end

  assign hit = |claim_clr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      claim_rvalid_q <= 1'b0;
      claim_id_q     <= '0;
    end else begin
      claim_rvalid_q <= claim_re_i;
      if (claim_re_i) claim_id_q <= hit ? irq_id_i : '0;
    end
  end

  assign claim_rvalid_o = claim_rvalid_q;
  assign claim_id_o     = claim_id_q;
  assign ip_o           = ip_q;
  assign ia_o           = ia_q;
endmodule

// File: tb/tb_rv_plic_claim_gateway.sv
// Directed table-driven bench for rv_plic_claim_gateway (default build, no sync).
module tb_rv_plic_claim_gateway;
  localparam int N  = 32;
  localparam int SW = 5;
`ifdef RV_PLIC_GW_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  src, le, ip, ia;
  logic          irq, cre, crv, cwe;
  logic [SW-1:0] irq_id, cid_o, cid_i;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv_plic_claim_gateway #(.N_SOURCE(N)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .src_i          (src),
    .le_i           (le),
    .irq_i          (irq),
    .irq_id_i       (irq_id),
    .claim_re_i     (cre),
    .claim_rvalid_o (crv),
    .claim_id_o     (cid_o),
    .complete_we_i  (cwe),
    .complete_id_i  (cid_i),
    .ip_o           (ip),
    .ia_o           (ia)
  );

  typedef struct {
    logic [N-1:0] src, le;
    logic         irq;
    int           irq_id;
    logic         cre, cwe;
    int           cid;
    logic         erv;
    int           eid;
    logic [N-1:0] eip, eia;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [N-1:0] s, input logic [N-1:0] l, input logic iq,
                     input int iid, input logic c_re, input logic c_we, input int c_id,
                     input logic erv, input int eid, input logic [N-1:0] eip,
                     input logic [N-1:0] eia);
    vec_t v;
    v.src = s; v.le = l; v.irq = iq; v.irq_id = iid; v.cre = c_re; v.cwe = c_we;
    v.cid = c_id; v.erv = erv; v.eid = eid; v.eip = eip; v.eia = eia;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // src, le, irq, irq_id, claim, complete, cid | rvalid, id, ip, ia
    // Level source 5: pend, claim, complete, re-pend while high
    add(32'h20, 0, 0, 0, 0, 0, 0,  0, 0, 32'h20, 32'h20);
    add(32'h20, 0, 1, 5, 0, 0, 0,  0, 0, 32'h20, 32'h20);
    add(32'h20, 0, 1, 5, 1, 0, 0,  1, 5, 32'h00, 32'h20);
    add(32'h20, 0, 0, 0, 0, 1, 5,  0, 5, 32'h00, 32'h00);
    add(32'h20, 0, 0, 0, 0, 0, 0,  0, 5, 32'h20, 32'h20);
    add(32'h00, 0, 1, 5, 1, 0, 0,  1, 5, 32'h00, 32'h20);
    add(32'h00, 0, 0, 0, 0, 1, 5,  0, 5, 32'h00, 32'h00);
    add(32'h00, 0, 0, 0, 0, 0, 0,  0, 5, 32'h00, 32'h00);
    // Edge source 3: pulses during service are lost
    add(32'h08, 8, 0, 0, 0, 0, 0,  0, 5, 32'h08, 32'h08);
    add(32'h00, 8, 1, 3, 1, 0, 0,  1, 3, 32'h00, 32'h08);
    add(32'h08, 8, 0, 0, 0, 0, 0,  0, 3, 32'h00, 32'h08);
    add(32'h00, 8, 0, 0, 0, 0, 0,  0, 3, 32'h00, 32'h08);
    add(32'h08, 8, 0, 0, 0, 0, 0,  0, 3, 32'h00, 32'h08);
    add(32'h00, 8, 0, 0, 0, 1, 3,  0, 3, 32'h00, 32'h00);
    add(32'h00, 8, 0, 0, 0, 0, 0,  0, 3, 32'h00, 32'h00);
    add(32'h08, 8, 0, 0, 0, 0, 0,  0, 3, 32'h08, 32'h08);
    add(32'h08, 8, 1, 3, 1, 0, 0,  1, 3, 32'h00, 32'h08);
    add(32'h08, 8, 0, 0, 0, 1, 3,  0, 3, 32'h00, 32'h00);
    add(32'h08, 8, 0, 0, 0, 0, 0,  0, 3, 32'h00, 32'h00);
    add(32'h00, 8, 0, 0, 0, 0, 0,  0, 3, 32'h00, 32'h00);
    // Sources 2 and 7: back-to-back claims with stale arbiter ID, irq=0 claim
    add(32'h84, 0, 0, 0, 0, 0, 0,  0, 3, 32'h84, 32'h84);
    add(32'h84, 0, 1, 7, 1, 0, 0,  1, 7, 32'h04, 32'h84);
    add(32'h84, 0, 1, 7, 1, 0, 0,  1, 0, 32'h04, 32'h84);
    add(32'h84, 0, 0, 2, 1, 0, 0,  1, 0, 32'h04, 32'h84);
    add(32'h84, 0, 1, 2, 1, 0, 0,  1, 2, 32'h00, 32'h84);
    add(32'h00, 0, 0, 0, 0, 1, 7,  0, 2, 32'h00, 32'h04);
    add(32'h00, 0, 0, 0, 0, 1, 2,  0, 2, 32'h00, 32'h00);
    // Ignored completes, then same-ID and different-ID claim+complete
    add(32'h50, 0, 0, 0, 0, 0, 0,  0, 2, 32'h50, 32'h50);
    add(32'h50, 0, 0, 0, 0, 1, 4,  0, 2, 32'h50, 32'h50);
    add(32'h50, 0, 0, 0, 0, 1, 0,  0, 2, 32'h50, 32'h50);
    add(32'h50, 0, 0, 0, 0, 1, 9,  0, 2, 32'h50, 32'h50);
    add(32'h50, 0, 1, 6, 1, 1, 6,  1, 6, 32'h10, 32'h50);
    add(32'h10, 0, 1, 4, 1, 1, 6,  1, 4, 32'h00, 32'h10);
    add(32'h00, 0, 0, 0, 0, 1, 4,  0, 4, 32'h00, 32'h00);
    add(32'h00, 0, 0, 0, 0, 0, 0,  0, 4, 32'h00, 32'h00);

    rst_n = 1'b0; src = '0; le = '0; irq = 1'b0; irq_id = '0;
    cre = 1'b0; cwe = 1'b0; cid_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rvalid", 32'(crv), 0);
    chk("reset_id", 32'(cid_o), 0);
    chk("reset_ip", ip, 0);
    chk("reset_ia", ia, 0);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      src = vecs[k].src; le = vecs[k].le; irq = vecs[k].irq;
      irq_id = SW'(vecs[k].irq_id); cre = vecs[k].cre; cwe = vecs[k].cwe;
      cid_i = SW'(vecs[k].cid);
      tick();
      chk($sformatf("v%0d_rvalid", k), 32'(crv), 32'(vecs[k].erv));
      chk($sformatf("v%0d_id", k), 32'(cid_o), vecs[k].eid);
      chk($sformatf("v%0d_ip", k), ip, vecs[k].eip);
      chk($sformatf("v%0d_ia", k), ia, vecs[k].eia);
    end

    // Reset asserted mid-claim: strobe discarded, outputs cleared asynchronously
    src = 32'h20; le = '0; irq = 1'b0; irq_id = '0; cre = 1'b0; cwe = 1'b0;
    tick();
    chk("pre_rst_ip", ip, 32'h20);
    irq = 1'b1; irq_id = 5; cre = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ip", ip, 0);
    chk("rst_async_ia", ia, 0);
    chk("rst_async_id", 32'(cid_o), 0);
    tick();
    chk("rst_hold_rvalid", 32'(crv), 0);
    cre = 1'b0; irq = 1'b0; irq_id = '0;
    src = 32'h08; le = 32'h08;
    rst_n = 1'b1;
    tick();
    // Edge source already high at release counts as a rising edge
    chk("post_rst_rvalid", 32'(crv), 0);
    chk("post_rst_id", 32'(cid_o), 0);
    chk("post_rst_ip", ip, 32'h08);
    chk("post_rst_ia", ia, 32'h08);

    // Source-to-ip latency, bounded wait
    begin
      int n;
      src = 32'h800; le = '0;
      n = 0;
      do begin
        tick();
        n++;
      end while (!ip[11] && n < 10);
      chk("src_to_ip_latency", n, LAT);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
